// File: rtl/dram.sv
// dram: 2048 x 16 single-port data RAM with a 24-bit write bus and registered read.
// The whole array clears on asynchronous reset, so it is built from flops, not a RAM macro.
module dram #(
    parameter int ADDR_WIDTH  = 11,
    parameter int WDATA_WIDTH = 24,
    parameter int RDATA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic [WDATA_WIDTH-1:0] write_data,
    output logic [RDATA_WIDTH-1:0] read_data,
    input  logic                   read_not_write,
    input  logic                   cs
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [RDATA_WIDTH-1:0] mem_q [DEPTH];
    logic [RDATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                   wr_en, rd_en, unused_wdata;
    assign wr_en        = cs & ~read_not_write;
    assign rd_en        = cs & read_not_write;
    assign read_data_d  = rd_en ? mem_q[address] : read_data_q;
    assign read_data    = read_data_q;
    // Upper write-bus bits are intentionally dropped.
    assign unused_wdata = ^write_data[WDATA_WIDTH-1:RDATA_WIDTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            read_data_q <= read_data_d;
            if (wr_en) mem_q[address] <= write_data[RDATA_WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_dram.sv
// tb_dram: directed scoreboard bench for dram; expected read_data values are queued
// from a reference memory model when stimulus is driven and compared after each edge.
module tb_dram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] address = '0;
    logic [23:0] write_data = '0;
    logic [15:0] read_data;
    logic        read_not_write = 1'b0;
    logic        cs = 1'b0;
    logic [15:0] mem_m [2048];
    logic [15:0] rd_m = '0;
    logic [15:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    dram dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .read_data(read_data), .read_not_write(read_not_write), .cs(cs)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: read_data=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic op(input logic c, input logic r, input logic [10:0] a,
                      input logic [23:0] w, input string tag);
        @(negedge clk);
        cs = c; read_not_write = r; address = a; write_data = w;
        if (c && r) rd_m = mem_m[a];
        else if (c) mem_m[a] = w[15:0];
        exp_q.push_back(rd_m);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else chk(tag, read_data, exp_q.pop_front());
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem_m[i] = '0;
        // reset state
        #12;
        chk("reset_value", read_data, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        // 1: cleared memory at both ends
        op(1, 1, 11'd0,    24'h0, "rd_addr0_after_reset");
        op(1, 1, 11'd2047, 24'h0, "rd_addr2047_after_reset");
        // 2: write then read next cycle; read_data unchanged during write
        op(1, 0, 11'd16, 24'd10, "wr16_hold");
        op(1, 1, 11'd16, 24'h0,  "rd16_new_data");
        // 3: upper write byte discarded
        op(1, 0, 11'd5, 24'hABCDEF, "wr5_hold");
        op(1, 1, 11'd5, 24'h0,      "rd5_low16");
        // 4: cs=0 is idle; read_data holds
        op(0, 0, 11'd16, 24'h1234, "idle_write_hold");
        op(0, 1, 11'd5,  24'h0,    "idle_read_hold");
        op(1, 1, 11'd16, 24'h0,    "rd16_unchanged_by_idle");
        // 5: boundary addresses
        op(1, 0, 11'd0,    24'h005555, "wr0");
        op(1, 0, 11'd2047, 24'hFFAAAA, "wr2047");
        op(1, 1, 11'd0,    24'h0, "rd0");
        op(1, 1, 11'd1,    24'h0, "rd1_zero");
        op(1, 1, 11'd2046, 24'h0, "rd2046_zero");
        op(1, 1, 11'd2047, 24'h0, "rd2047");
        // mixed traffic over a small window so reads hit written words
        for (int k = 0; k < 40; k++)
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               11'($urandom_range(0, 15)), 24'($urandom), "random_op");
        op(1, 1, 11'd2047, 24'h0, "rd2047_before_reset");
        // 6: async reset between edges aborts a pending write
        @(negedge clk);
        cs = 1'b1; read_not_write = 1'b0; address = 11'd16; write_data = 24'h000077;
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_immediate", read_data, 16'h0000);
        for (int i = 0; i < 2048; i++) mem_m[i] = '0;
        rd_m = '0;
        @(posedge clk);
        #1;
        chk("reset_held", read_data, 16'h0000);
        @(negedge clk);
        cs = 1'b0;
        rst = 1'b0;
        op(1, 1, 11'd16,   24'h0, "rd16_after_reset");
        op(1, 1, 11'd5,    24'h0, "rd5_after_reset");
        op(1, 1, 11'd2047, 24'h0, "rd2047_after_reset");
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
